input_debouncer: RTL and testbench

//   Conditions N raw board inputs (slide switches / push buttons) before they drive the gate-test logic.
//   Per channel: multi-flop synchronizer, then a stability counter, producing a glitch-free level.

---
 rtl/input_debouncer.sv | 113 +++++++++++
 tb/tb_input_debouncer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// input_debouncer: per-channel synchronizer plus stability counter for raw
// board inputs. Each channel is one input_debouncer_lane instance.
// Optional feature: define DEBOUNCE_EDGE_EN to add the rise_pulse/fall_pulse
// one-cycle strobes on clean_out transitions.

module input_debouncer_lane #(
  parameter int   SYNC_STAGES = 2,
  parameter int   STABLE_CNT  = 50000,
  parameter int   CNT_W       = 16,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
`ifdef DEBOUNCE_EDGE_EN
  output logic rise_pulse,
  output logic fall_pulse,
`endif
  output logic clean,
  output logic busy
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CNT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   s;

  // Plain flop chain: no logic between stages so metastability can settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {SYNC_STAGES{RESET_VAL}};
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Qualify a differing level for STABLE_CNT cycles; any agreement restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      clean <= RESET_VAL;
    end else if (s == clean) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
      clean <= s;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign busy = (cnt_q != '0);

`ifdef DEBOUNCE_EDGE_EN
  logic clean_d;

  // Compare against a delayed copy that resets to the same level, so reset
  // release never produces a strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clean_d    <= RESET_VAL;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      clean_d    <= clean;
      rise_pulse <= clean & ~clean_d;
      fall_pulse <= ~clean & clean_d;
    end
  end
`endif
endmodule

module input_debouncer #(
  parameter int   N           = 2,
  parameter int   SYNC_STAGES = 2,
  parameter int   STABLE_CNT  = 50000,
  parameter int   CNT_W       = 16,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] raw_in,
`ifdef DEBOUNCE_EDGE_EN
  output logic [N-1:0] rise_pulse,
  output logic [N-1:0] fall_pulse,
`endif
  output logic [N-1:0] clean_out,
  output logic [N-1:0] busy
);
  // Reject configurations the counter or synchronizer cannot support.
  if (STABLE_CNT == 0 || STABLE_CNT >= (1 << CNT_W) || SYNC_STAGES < 2) begin : g_bad_cfg
    $error("input_debouncer: illegal STABLE_CNT/CNT_W/SYNC_STAGES");
  end

  // One fully independent lane per channel.
  for (genvar i = 0; i < N; i++) begin : g_lane
    input_debouncer_lane #(
      .SYNC_STAGES(SYNC_STAGES),
      .STABLE_CNT (STABLE_CNT),
      .CNT_W      (CNT_W),
      .RESET_VAL  (RESET_VAL)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .raw       (raw_in[i]),
`ifdef DEBOUNCE_EDGE_EN
      .rise_pulse(rise_pulse[i]),
      .fall_pulse(fall_pulse[i]),
`endif
      .clean     (clean_out[i]),
      .busy      (busy[i])
    );
  end
endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with N=2, SYNC_STAGES=2, STABLE_CNT=4,
// CNT_W=3. Inputs change 1 time unit after a rising edge; outputs are
// sampled at that same point, so "edge k" means the k-th rising edge after
// the input change.

module tb_input_debouncer;
  localparam int N = 2;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] raw_in;
  logic [N-1:0] clean_out;
  logic [N-1:0] busy;
  logic [N-1:0] rise_pulse;
  logic [N-1:0] fall_pulse;

  int vec_cnt = 0;
  int err_cnt = 0;

  input_debouncer #(
    .N(N), .SYNC_STAGES(2), .STABLE_CNT(4), .CNT_W(3), .RESET_VAL(1'b0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw_in    (raw_in),
`ifdef DEBOUNCE_EDGE_EN
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
`endif
    .clean_out (clean_out),
    .busy      (busy)
  );

`ifndef DEBOUNCE_EDGE_EN
  assign rise_pulse = '0;
  assign fall_pulse = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Async reset pulse entirely between two edges, with raw_in set to v.
  task automatic do_reset(input logic [N-1:0] v);
    raw_in = v;
    rst_n  = 1'b0;
    #2;
    rst_n  = 1'b1;
  endtask

  task automatic chk_pulses(input string tag, input logic [N-1:0] r, input logic [N-1:0] f);
`ifdef DEBOUNCE_EDGE_EN
    chk({tag, "_rise"}, rise_pulse, r);
    chk({tag, "_fall"}, fall_pulse, f);
`endif
  endtask

  initial begin
    rst_n  = 1'b0;
    raw_in = 2'b11;
    #23;
    // 1: reset state with raw inputs high, then 6-edge acceptance
    chk("rst_clean", clean_out, 2'b00);
    chk("rst_busy", busy, 2'b00);
    chk_pulses("rst", 2'b00, 2'b00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(3);
    chk("t1_busy_e3", busy, 2'b11);
    tick(2);
    chk("t1_clean_e5", clean_out, 2'b00);
    tick(1);
    chk("t1_clean_e6", clean_out, 2'b11);
    chk_pulses("t1_e6", 2'b00, 2'b00);
    tick(1);
    chk_pulses("t1_e7", 2'b11, 2'b00);

    // 2: clean step on channel 0
    do_reset(2'b00);
    tick(1);
    raw_in = 2'b01;
    tick(2);
    chk("t2_busy_e2", busy, 2'b00);
    tick(1);
    chk("t2_busy_e3", busy, 2'b01);
    tick(2);
    chk("t2_busy_e5", busy, 2'b01);
    chk("t2_clean_e5", clean_out, 2'b00);
    tick(1);
    chk("t2_clean_e6", clean_out, 2'b01);
    chk("t2_busy_e6", busy, 2'b00);
    chk_pulses("t2_e6", 2'b00, 2'b00);
    tick(1);
    chk_pulses("t2_e7", 2'b01, 2'b00);
    tick(1);
    chk_pulses("t2_e8", 2'b00, 2'b00);

    // 3: 3-cycle glitch on channel 0 is rejected
    do_reset(2'b00);
    tick(1);
    raw_in = 2'b01;
    tick(3);
    raw_in = 2'b00;
    tick(2);
    chk("t3_busy_e5", busy, 2'b01);
    tick(1);
    chk("t3_busy_e6", busy, 2'b00);
    for (int i = 0; i < 4; i++) begin
      chk("t3_clean", clean_out, 2'b00);
      chk_pulses("t3", 2'b00, 2'b00);
      tick(1);
    end

    // 4: bounce on channel 1; final rising sample at edge 5
    do_reset(2'b00);
    tick(1);
    raw_in = 2'b10; tick(1);
    raw_in = 2'b00; tick(1);
    raw_in = 2'b10; tick(1);
    raw_in = 2'b00; tick(1);
    chk("t4_busy_e4", busy, 2'b00);
    raw_in = 2'b10; tick(1);
    for (int e = 6; e <= 9; e++) begin
      tick(1);
      chk("t4_clean_hold", clean_out, 2'b00);
    end
    tick(1);
    chk("t4_clean_e10", clean_out, 2'b10);

    // 5: simultaneous rise, then channel 1 falls alone
    do_reset(2'b00);
    tick(1);
    raw_in = 2'b11;
    tick(5);
    chk("t5_clean_e5", clean_out, 2'b00);
    tick(1);
    chk("t5_clean_e6", clean_out, 2'b11);
    tick(1);
    chk_pulses("t5_e7", 2'b11, 2'b00);
    raw_in = 2'b01;
    tick(5);
    chk("t5_fall_e5", clean_out, 2'b11);
    tick(1);
    chk("t5_fall_e6", clean_out, 2'b01);
    tick(1);
    chk_pulses("t5_fall_e7", 2'b00, 2'b10);
    tick(1);
    chk_pulses("t5_fall_e8", 2'b00, 2'b00);

    // 6: reset mid-qualification discards the count
    do_reset(2'b00);
    tick(1);
    raw_in = 2'b01;
    tick(4);
    chk("t6_busy_pre", busy, 2'b01);
    rst_n = 1'b0;
    #1;
    chk("t6_busy_rst", busy, 2'b00);
    chk("t6_clean_rst", clean_out, 2'b00);
    #1;
    rst_n = 1'b1;
    tick(2);
    chk("t6_busy_e2", busy, 2'b00);
    tick(3);
    chk("t6_clean_e5", clean_out, 2'b00);
    tick(1);
    chk("t6_clean_e6", clean_out, 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
